prog_loader: RTL
================

Name: prog_loader

Overview:
- Upstream host-side stage for the 9-bit CPU `top_level`.
- Accepts a stream of 9-bit instruction words and writes them sequentially into instruction memory from address 0 through its write port.
- After the final word it pulses `start` to the CPU, then waits for the CPU's `done`.
- Reports completion, the CPU run-cycle count, and error conditions (program overflow, run timeout).

Parameters:
- IW, 9, instruction word width
- AW, 10, instruction memory address width (depth 2**AW)
- CW, 16, cycle-counter width
- TIMEOUT, 16'hFFFF, maximum RUN cycles before abort (TIMEOUT < 2**CW)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- load_go  in  1  begin a new load; sampled in IDLE, DONE, ERR
- in_valid  in  1  stream word valid
- in_ready  out  1  loader can accept a word
- in_word  in  IW  instruction word
- in_last  in  1  marks final word of program
- im_we  out  1  instruction memory write enable
- im_addr  out  AW  write address
- im_wdata  out  IW  write data
- start  out  1  CPU start pulse
- done  in  1  CPU finished (level)
- busy  out  1  high in LOAD, SETTLE, LAUNCH, RUN
- finished  out  1  high in DONE
- err  out  1  high in ERR
- err_code  out  2  0 none, 1 overflow, 2 timeout
- words_loaded  out  AW+1  count of words written
- cyc_count  out  CW  RUN cycles elapsed

Behaviour:
- Interface: one clock, `clk`. Synchronous active-high `reset`.
- Reset: state goes to IDLE. All outputs go to 0 (`in_ready`, `im_we`, `im_addr`, `im_wdata`, `start`, `busy`, `finished`, `err`, `err_code`, `words_loaded`, `cyc_count`).
- Reset mid-operation: same result at the next edge. A write in flight is dropped (`im_we` is 0 in the following cycle). `start` is never emitted.
- States: IDLE, LOAD, SETTLE, LAUNCH, RUN, DONE, ERR.
- IDLE / DONE / ERR + `load_go`=1 → LOAD.
  - On entry: clear `words_loaded`, `cyc_count`, `err_code`. Next write address is 0.
- LOAD:
  - `in_ready`=1 combinationally from state. A word is accepted on cycle k when `in_valid & in_ready`.
  - Write is registered: in cycle k+1, `im_we`=1, `im_addr`=accept index, `im_wdata`=word. `words_loaded` increments at the same edge.
  - One word per cycle is sustainable. `in_valid`=0 causes no write and no advance.
- Final word (`in_last`=1 on accept) → SETTLE.
  - SETTLE lasts 1 cycle, in which the last write occurs.
  - Then LAUNCH: 1 cycle, `start`=1.
  - Then RUN.
- Overflow: a word accepted at address 2**AW−1 with `in_last`=0.
  - That word is still written.
  - State → ERR, `err_code`=1. No launch.
  - `words_loaded` = 2**AW.
- RUN:
  - `start`=0. `cyc_count` increments each cycle that `done`=0.
  - `done`=1 → DONE with `cyc_count` frozen; the `done` cycle is not counted.
  - `done` is ignored in every state except RUN. A stale `done` during LAUNCH does not terminate the run.
- Timeout: `cyc_count` reaching TIMEOUT in RUN → ERR, `err_code`=2, count frozen at TIMEOUT.
  - If `done` and the timeout condition coincide, `done` wins (DONE).
- DONE: `finished`=1, holds until `load_go` or `reset`.
- ERR: `err`=1, holds until `load_go` or `reset`.
- `load_go` in LOAD..RUN is ignored.
- `in_valid` outside LOAD is ignored (`in_ready`=0). No writes occur.
- Latency: last accept at cycle k → `start` high in cycle k+2 → RUN from k+3.

Decomposition:
- Add `ldr_state_t` (7-state enum) and the `err_code` constants (`ERR_NONE`, `ERR_OVF`, `ERR_TMO`) to `code_pack`.
- One sub-module is natural: `sat_counter` (width-parameterized, clear/enable, saturating at a limit, `at_limit` flag), used for `cyc_count`.
- Address/write register and FSM stay in `prog_loader`.

Test Plan:
- Program load and run:
  - Stimulus: reset, `load_go`, stream 31 words back-to-back (the 9-bit encodings of the existing `stor`/`load`/`mthr` test program), `in_last` on word 30.
  - Response: `im_we` pulses at addresses 0..30 in order with matching data. `start` high exactly one cycle, two cycles after the last accept. `words_loaded`=31.
- Run-cycle count:
  - Stimulus: load 3 words; CPU model raises `done` 10 cycles into RUN.
  - Response: `finished`=1, `cyc_count`=10, `busy`=0.
- Gapped stream and stale `done`:
  - Stimulus: `in_valid` toggles 1,0,0,1,1 with 3 words; `done` held high from LOAD through LAUNCH.
  - Response: writes only on accepted words, addresses 0,1,2. `done` is not acted on until RUN; run ends on the first RUN cycle with `cyc_count`=0.
- Overflow:
  - Stimulus: AW=3, stream 9 words with no `in_last`.
  - Response: 8 writes at addresses 0..7, `err`=1, `err_code`=1, `in_ready`=0 for the 9th word, `start` never asserted.
- Timeout:
  - Stimulus: TIMEOUT=20, `done` never asserted.
  - Response: ERR after 20 RUN cycles, `err_code`=2, `cyc_count`=20.
  - Stimulus: second `load_go` from ERR.
  - Response: counters clear and a new load proceeds.
- Reset mid-operation:
  - Stimulus: `reset` in the cycle following an accept, and separately during RUN.
  - Response: next cycle `im_we`=0, `start`=0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader FSM states and error codes.
package prog_loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, LAUNCH, RUN, DONE, ERR} ldr_state_t;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: instruction stream in, instruction-memory write port out.
interface prog_loader_if #(
    parameter int IW = 9,
    parameter int AW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_word;
    logic          in_last;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [IW-1:0] im_wdata;
    modport master (output in_valid, in_word, in_last, input in_ready, im_we, im_addr, im_wdata);
    modport slave  (input in_valid, in_word, in_last, output in_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/prog_loader_sat_counter.sv
// sat_counter: clearable up-counter that saturates at LIMIT.
module sat_counter #(
    parameter int             W     = 16,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         at_limit
);
    // also true in the cycle whose increment lands on LIMIT, so callers can react on that edge
    assign at_limit = (q == LIMIT) || (en && q == LIMIT - W'(1));
    always_ff @(posedge clk) begin
        if (reset || clr) q <= '0;
        else if (en && q != LIMIT) q <= q + W'(1);
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, launches the CPU and times its run.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int            IW      = 9,
    parameter int            AW      = 10,
    parameter int            CW      = 16,
    parameter logic [CW-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_go,
    prog_loader_if.slave  bus,
    output logic          start,
    input  logic          done,
    output logic          busy,
    output logic          finished,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW:0]   words_loaded,
    output logic [CW-1:0] cyc_count
);
    ldr_state_t state, state_n;
    logic go, acc, ovf, tmo, cyc_en, cyc_hit;
    assign go       = load_go && (state == IDLE || state == DONE || state == ERR);
    assign acc      = state == LOAD && bus.in_valid;
    assign ovf      = acc && !bus.in_last && words_loaded == {1'b0, {AW{1'b1}}};
    assign cyc_en   = state == RUN && !done;
    assign tmo      = cyc_en && cyc_hit;
    assign bus.in_ready = state == LOAD;
    assign start    = state == LAUNCH;
    assign busy     = state == LOAD || state == SETTLE || state == LAUNCH || state == RUN;
    assign finished = state == DONE;
    assign err      = state == ERR;
    sat_counter #(.W(CW), .LIMIT(TIMEOUT)) u_cyc (
        .clk      (clk),
        .reset    (reset),
        .clr      (go),
        .en       (cyc_en),
        .q        (cyc_count),
        .at_limit (cyc_hit)
    );
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE, ERR: state_n = go ? LOAD : state;
            LOAD:            state_n = (acc && bus.in_last) ? SETTLE : ovf ? ERR : LOAD;
            SETTLE:          state_n = LAUNCH;
            LAUNCH:          state_n = RUN;
            RUN:             state_n = done ? DONE : tmo ? ERR : RUN;
            default:         state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            words_loaded <= '0;
            err_code     <= ERR_NONE;
        end else begin
            state     <= state_n;
            bus.im_we <= acc;
            if (acc) begin
                bus.im_addr  <= words_loaded[AW-1:0];
                bus.im_wdata <= bus.in_word;
                words_loaded <= words_loaded + (AW+1)'(1);
            end
            if (go) begin
                words_loaded <= '0;
                err_code     <= ERR_NONE;
            end else if (ovf) err_code <= ERR_OVF;
            else if (tmo) err_code <= ERR_TMO;
        end
    end
endmodule
